// File: rtl/seq_datapath.sv
// seq_datapath: self-sequencing memory-to-memory ALU engine.
// A Start command fetches two operands from internal RAM, runs ADD/SUB
// (one cycle) or MUL/DIV (WIDTH-cycle shift-add / restoring), writes the
// result back to RAM and pulses Done. A host port preloads/inspects RAM.
//
// Ports:
//   Clock, Reset (async, active low)
//   Start, Op[1:0], Addr_A/Addr_B/Addr_D   command (sampled in IDLE only)
//   Busy, Done, Result, Div_Zero           status / last result
//   Host_We, Host_Addr, Host_Wdata         host write (ignored while Busy)
//   Host_Rdata                             registered host read, 1-cycle latency
module seq_datapath #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [ADDR_W-1:0] Addr_A,
  input  logic [ADDR_W-1:0] Addr_B,
  input  logic [ADDR_W-1:0] Addr_D,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  Result,
  output logic              Div_Zero,
  input  logic              Host_We,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [WIDTH-1:0]  Host_Wdata,
  output logic [WIDTH-1:0]  Host_Rdata
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_B, S_LATCH_B, S_EXEC, S_STORE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [ADDR_W-1:0]  a_q, a_d, b_q, b_d, d_q, d_d;
  logic [WIDTH-1:0]   ra_q, ra_d, rb_q, rb_d;
  logic [WIDTH-1:0]   acc_q, acc_d, rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   host_rdata_q;

  // RAM (not reset) and its internal synchronous read port
  logic [WIDTH-1:0]   mem_q [2**ADDR_W];
  logic [WIDTH-1:0]   rd_data_q;
  logic [ADDR_W-1:0]  rd_addr;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;

  // restoring-division step temporaries
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               q_bit;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    dz_d      = dz_q;
    mem_we    = 1'b0;
    mem_waddr = Host_Addr;
    mem_wdata = Host_Wdata;
    rd_addr   = (state_q == S_FETCH_B) ? b_q : a_q;
    rem_sh    = {rem_q, ra_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, rb_q};
    q_bit     = (rem_sh >= {1'b0, rb_q});

    case (state_q)
      S_IDLE: begin
        // host owns the write port only while the engine is idle
        mem_we = Host_We;
        if (Start) begin
          op_d    = Op;
          a_d     = Addr_A;
          b_d     = Addr_B;
          d_d     = Addr_D;
          dz_d    = 1'b0;
          state_d = S_FETCH_A;
        end
      end
      S_FETCH_A: state_d = S_FETCH_B;
      S_FETCH_B: begin
        ra_d    = rd_data_q;
        state_d = S_LATCH_B;
      end
      S_LATCH_B: begin
        rb_d    = rd_data_q;
        acc_d   = '0;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            acc_d   = ra_q + rb_q;
            state_d = S_STORE;
          end
          OP_SUB: begin
            acc_d   = ra_q - rb_q;
            state_d = S_STORE;
          end
          OP_MUL: begin
            // Ra walks left, Rb walks right; only the low WIDTH bits are kept
            if (rb_q[0]) acc_d = acc_q + ra_q;
            ra_d  = ra_q << 1;
            rb_d  = rb_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_STORE;
          end
          default: begin
            // Ra shifts dividend bits into the remainder; Rb (divisor) is kept
            // so the zero-divisor flag can be derived at STORE. With Rb=0 every
            // step subtracts, which yields the all-ones quotient naturally.
            if (q_bit) rem_d = rem_diff[WIDTH-1:0];
            else       rem_d = rem_sh[WIDTH-1:0];
            acc_d = {acc_q[WIDTH-2:0], q_bit};
            ra_d  = ra_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_STORE;
          end
        endcase
      end
      S_STORE: begin
        mem_we    = 1'b1;
        mem_waddr = d_q;
        mem_wdata = acc_q;
        result_d  = acc_q;
        dz_d      = (op_q == OP_DIV) && (rb_q == '0);
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      d_q          <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      acc_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      dz_q         <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      d_q          <= d_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      dz_q         <= dz_d;
      // read-before-write: same-edge write is not seen until the next read
      host_rdata_q <= mem_q[Host_Addr];
    end
  end

  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    rd_data_q <= mem_q[rd_addr];
  end

  assign Busy       = (state_q != S_IDLE);
  assign Done       = (state_q == S_DONE);
  assign Result     = result_q;
  assign Div_Zero   = dz_q;
  assign Host_Rdata = host_rdata_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath (WIDTH=16, ADDR_W=8): each Start pushes
// the expected Result/Div_Zero/Done cycle; a monitor pops on every Done.
module tb_seq_datapath;
  localparam int W = 16;
  localparam int AW = 8;

  logic          Clock, Reset, Start, Busy, Done, Div_Zero, Host_We;
  logic [1:0]    Op;
  logic [AW-1:0] Addr_A, Addr_B, Addr_D, Host_Addr;
  logic [W-1:0]  Result, Host_Wdata, Host_Rdata;

  seq_datapath #(.WIDTH(W), .ADDR_W(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .Addr_A(Addr_A), .Addr_B(Addr_B), .Addr_D(Addr_D),
    .Busy(Busy), .Done(Done), .Result(Result), .Div_Zero(Div_Zero),
    .Host_We(Host_We), .Host_Addr(Host_Addr), .Host_Wdata(Host_Wdata),
    .Host_Rdata(Host_Rdata)
  );

  typedef struct { logic [W-1:0] res; logic dz; int cyc; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // monitor: every Done must match the oldest pending expectation
  always @(negedge Clock) begin
    if (Reset && Done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(Result), 32'(e.res));
        chk("div_zero", 32'(Div_Zero), 32'(e.dz));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic hwrite(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge Clock);
    Host_We = 1'b1; Host_Addr = a; Host_Wdata = d;
    @(negedge Clock);
    Host_We = 1'b0;
  endtask

  task automatic hread(input string nm, input logic [AW-1:0] a, input logic [W-1:0] exp);
    @(negedge Clock);
    Host_Addr = a;
    @(negedge Clock);
    chk(nm, 32'(Host_Rdata), 32'(exp));
  endtask

  task automatic start(input logic [1:0] op, input logic [AW-1:0] a, b, d,
                       input logic [W-1:0] res, input logic dz);
    exp_t e;
    int lat;
    lat = (op[1]) ? W + 4 : 5;
    @(negedge Clock);
    Start = 1'b1; Op = op; Addr_A = a; Addr_B = b; Addr_D = d;
    e.res = res; e.dz = dz; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
    chk("busy_after_start", 32'(Busy), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge Clock);
      if (!Busy && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Op = '0; Addr_A = '0; Addr_B = '0; Addr_D = '0;
    Host_We = 1'b0; Host_Addr = '0; Host_Wdata = '0;
    repeat (2) @(negedge Clock);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_dz", 32'(Div_Zero), 32'd0);
    chk("rst_rdata", 32'(Host_Rdata), 32'd0);
    Reset = 1'b1;

    // ADD / SUB, including destination equal to an operand
    hwrite(3, 16'h0005);
    hwrite(4, 16'h0007);
    hread("host_rw", 4, 16'h0007);
    start(2'd0, 3, 4, 10, 16'h000C, 1'b0);
    wait_idle();
    chk("busy_low", 32'(Busy), 32'd0);
    hread("mem10", 10, 16'h000C);
    start(2'd1, 3, 4, 11, 16'hFFFE, 1'b0);
    wait_idle();
    hread("mem11", 11, 16'hFFFE);
    start(2'd1, 4, 3, 4, 16'h0002, 1'b0);
    wait_idle();
    hread("mem4_overwrite", 4, 16'h0002);

    // MUL
    hwrite(5, 16'h0123);
    hwrite(6, 16'h0010);
    start(2'd2, 5, 6, 12, 16'h1230, 1'b0);
    wait_idle();
    hread("mem12", 12, 16'h1230);
    hwrite(7, 16'hFFFF);
    start(2'd2, 7, 7, 13, 16'h0001, 1'b0);
    wait_idle();

    // DIV, divide by zero, flag cleared by next Start
    hwrite(8, 16'd100);
    hwrite(9, 16'd7);
    start(2'd3, 8, 9, 14, 16'h000E, 1'b0);
    wait_idle();
    hwrite(9, 16'd0);
    start(2'd3, 8, 9, 15, 16'hFFFF, 1'b1);
    wait_idle();
    chk("dz_held", 32'(Div_Zero), 32'd1);
    hread("mem15", 15, 16'hFFFF);
    start(2'd0, 3, 4, 19, 16'h0007, 1'b0);
    chk("dz_cleared", 32'(Div_Zero), 32'd0);
    wait_idle();

    // Start and host write during MUL EXEC are ignored
    hwrite(20, 16'h1111);
    start(2'd2, 5, 6, 16, 16'h1230, 1'b0);
    repeat (3) @(negedge Clock);
    Start = 1'b1; Op = 2'd0; Addr_A = 3; Addr_B = 4; Addr_D = 21;
    Host_We = 1'b1; Host_Addr = 20; Host_Wdata = 16'hBEEF;
    @(negedge Clock);
    Start = 1'b0; Host_We = 1'b0;
    wait_idle();
    repeat (8) @(negedge Clock);
    hread("mem20_kept", 20, 16'h1111);
    hread("mem16", 16, 16'h1230);

    // reset mid-MUL EXEC aborts without storing
    hwrite(17, 16'h5A5A);
    start(2'd2, 5, 6, 17, 16'h1230, 1'b0);
    repeat (6) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_result", 32'(Result), 32'd0);
    chk("abort_dz", 32'(Div_Zero), 32'd0);
    sb.delete();
    @(negedge Clock);
    Reset = 1'b1;
    hread("mem17_kept", 17, 16'h5A5A);
    start(2'd0, 3, 6, 18, 16'h0015, 1'b0);
    wait_idle();
    hread("mem18", 18, 16'h0015);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
